// File: rtl/fpu_round_sched.sv
// Round-robin scheduler sharing one combinational fpu_rounder among NREQ requesters.
// One operation in flight: grant, drive the rounder for one cycle, hold the result until accepted.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for any req_valid; grants one requester round-robin
// ST_ROUND | latched operands drive rnd_*; rounder result captured at edge
// ST_DONE  | res_valid high, res_* held until res_ready
module fpu_round_sched #(
   parameter int NREQ = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [48*NREQ-1:0]   req_mantissa,
   input  logic [9*NREQ-1:0]    req_exponent,
   input  logic [NREQ-1:0]      req_sign,
   input  logic [3*NREQ-1:0]    req_grs,
   input  logic [3*NREQ-1:0]    req_rm,
   input  logic [2:0]           frm,
   output logic [47:0]          rnd_mantissa,
   output logic [8:0]           rnd_exponent,
   output logic                 rnd_sign,
   output logic                 rnd_guard,
   output logic                 rnd_round,
   output logic                 rnd_sticky,
   output logic [2:0]           rnd_rm,
   input  logic [22:0]          rnd_mantissa_rounded,
   input  logic [7:0]           rnd_exponent_rounded,
   input  logic                 rnd_inexact,
   input  logic                 rnd_overflow,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [1:0]           res_tag,
   output logic [22:0]          res_mantissa,
   output logic [7:0]           res_exponent,
   output logic                 res_sign,
   output logic                 res_inexact,
   output logic                 res_overflow,
   output logic                 res_illegal,
   output logic [4:0]           fflags,
   input  logic                 fflags_clr,
   output logic                 busy
);

   localparam int TW = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [TW-1:0]     r_last_grant;
   logic [TW:0]       w_cand;
   logic [TW-1:0]     w_gnt_idx;
   logic              w_gnt_found;
   logic              w_grant;

   logic [2:0]        w_req_rm;
   logic [2:0]        w_rm_resolved;

   logic [47:0]       r_mant;
   logic [8:0]        r_exp;
   logic              r_sign;
   logic [2:0]        r_grs;
   logic [2:0]        r_rm;
   logic [TW-1:0]     r_tag;

   logic [TW-1:0]     r_res_tag;
   logic [22:0]       r_res_mant;
   logic [7:0]        r_res_exp;
   logic              r_res_sign;
   logic              r_res_inexact;
   logic              r_res_overflow;
   logic              r_res_illegal;
   logic [4:0]        r_fflags;
   logic [4:0]        w_flag_set;

   logic              w_in_round;
   logic              w_illegal;

   // Search starts one past the last grant so every requester gets a turn.
   always_comb begin
      w_gnt_found = 1'b0;
      w_gnt_idx   = '0;
      w_cand      = '0;
      for (int off = 1; off <= NREQ; off++) begin
         w_cand = {1'b0, r_last_grant} + (TW+1)'(off);
         if (w_cand >= (TW+1)'(NREQ)) begin
            w_cand = w_cand - (TW+1)'(NREQ);
         end
         if (!w_gnt_found && req_valid[w_cand[TW-1:0]]) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = w_cand[TW-1:0];
         end
      end
   end

   assign w_grant = (r_state == ST_IDLE) && w_gnt_found && !rst;

   always_comb begin
      req_ready = '0;
      if (w_grant) begin
         req_ready[w_gnt_idx] = 1'b1;
      end
   end

   assign w_req_rm      = req_rm[int'(w_gnt_idx)*3 +: 3];
   assign w_rm_resolved = (w_req_rm == 3'b111) ? frm : w_req_rm;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_grant) begin
               w_state_nxt = ST_ROUND;
            end
         end
         ST_ROUND: begin
            w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (res_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= TW'(NREQ-1);
         r_mant       <= '0;
         r_exp        <= '0;
         r_sign       <= 1'b0;
         r_grs        <= '0;
         r_rm         <= '0;
         r_tag        <= '0;
      end else if (w_grant) begin
         r_last_grant <= w_gnt_idx;
         r_mant       <= req_mantissa[int'(w_gnt_idx)*48 +: 48];
         r_exp        <= req_exponent[int'(w_gnt_idx)*9 +: 9];
         r_sign       <= req_sign[w_gnt_idx];
         r_grs        <= req_grs[int'(w_gnt_idx)*3 +: 3];
         r_rm         <= w_rm_resolved;
         r_tag        <= w_gnt_idx;
      end
   end

   assign w_in_round = (r_state == ST_ROUND);
   // 101/110 are reserved encodings; 111 here means frm itself was dynamic.
   assign w_illegal  = (r_rm >= 3'b101);

   assign rnd_mantissa = w_in_round ? r_mant   : '0;
   assign rnd_exponent = w_in_round ? r_exp    : '0;
   assign rnd_sign     = w_in_round ? r_sign   : 1'b0;
   assign rnd_guard    = w_in_round ? r_grs[2] : 1'b0;
   assign rnd_round    = w_in_round ? r_grs[1] : 1'b0;
   assign rnd_sticky   = w_in_round ? r_grs[0] : 1'b0;
   assign rnd_rm       = w_in_round ? r_rm     : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_res_tag      <= '0;
         r_res_mant     <= '0;
         r_res_exp      <= '0;
         r_res_sign     <= 1'b0;
         r_res_inexact  <= 1'b0;
         r_res_overflow <= 1'b0;
         r_res_illegal  <= 1'b0;
      end else if (w_in_round) begin
         r_res_tag  <= r_tag;
         r_res_sign <= r_sign;
         if (w_illegal) begin
            r_res_mant     <= '0;
            r_res_exp      <= '0;
            r_res_inexact  <= 1'b0;
            r_res_overflow <= 1'b0;
            r_res_illegal  <= 1'b1;
         end else begin
            r_res_mant     <= rnd_mantissa_rounded;
            r_res_exp      <= rnd_exponent_rounded;
            r_res_inexact  <= rnd_inexact;
            r_res_overflow <= rnd_overflow;
            r_res_illegal  <= 1'b0;
         end
      end
   end

   // Only OF and NX are produced here; a same-cycle clear keeps the new bits.
   assign w_flag_set = (w_in_round && !w_illegal)
                     ? {2'b00, rnd_overflow, 1'b0, rnd_inexact | rnd_overflow}
                     : 5'b00000;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fflags <= '0;
      end else begin
         r_fflags <= (fflags_clr ? 5'b00000 : r_fflags) | w_flag_set;
      end
   end

   assign res_valid    = (r_state == ST_DONE);
   assign res_tag      = r_res_tag;
   assign res_mantissa = r_res_mant;
   assign res_exponent = r_res_exp;
   assign res_sign     = r_res_sign;
   assign res_inexact  = r_res_inexact;
   assign res_overflow = r_res_overflow;
   assign res_illegal  = r_res_illegal;
   assign fflags       = r_fflags;
   assign busy         = (r_state != ST_IDLE);

endmodule

// File: doc/fpu_round_sched.md
FPU_ROUND_SCHED -- requirements
Module: fpu_round_sched

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of requesters sharing one fpu_rounder (tag width 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  NREQ  per-requester request.
REQ-005 SHALL have port req_ready  output  NREQ  one-hot grant/accept strobe.
REQ-006 SHALL have port req_mantissa  input  48*NREQ  packed; slice i is requester i.
REQ-007 SHALL have port req_exponent  input  9*NREQ  packed biased exponents.
REQ-008 SHALL have port req_sign  input  NREQ  signs.
REQ-009 SHALL have port req_grs  input  3*NREQ  packed {guard,round,sticky}.
REQ-010 SHALL have port req_rm  input  3*NREQ  packed instruction rm; 3'b111 = dynamic.
REQ-011 SHALL have port frm  input  3  CSR rounding mode.
REQ-012 SHALL have ports rnd_mantissa[47:0], rnd_exponent[8:0], rnd_sign, rnd_guard, rnd_round, rnd_sticky, rnd_rm[2:0]  output  driving the external combinational fpu_rounder.
REQ-013 SHALL have ports rnd_mantissa_rounded[22:0], rnd_exponent_rounded[7:0], rnd_inexact, rnd_overflow  input  returned from the rounder.
REQ-014 SHALL have ports res_valid output 1, res_ready input 1, res_tag output 2, res_mantissa output 23, res_exponent output 8, res_sign output 1, res_inexact output 1, res_overflow output 1, res_illegal output 1.
REQ-015 SHALL have port fflags  output  5  accrued {NV,DZ,OF,UF,NX}.
REQ-016 SHALL have port fflags_clr  input  1  clear accrued flags.
REQ-017 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-018 SHALL implement FSM IDLE -> ROUND -> DONE -> IDLE, one op in flight.
REQ-019 IDLE: if any req_valid, SHALL grant one requester round-robin starting at (last_grant+1) mod NREQ, assert its req_ready for that cycle only, latch its operands, tag and resolved rm, and go to ROUND.
REQ-020 req_ready SHALL be zero in ROUND and DONE and when no req_valid is high; never more than one bit set.
REQ-021 Resolved rm SHALL be frm sampled at the grant cycle when req_rm=3'b111, else req_rm.
REQ-022 ROUND: rnd_* SHALL be driven from latched operands; rounder outputs SHALL be captured into res_* at the end of the cycle; state -> DONE.
REQ-023 rnd_* outputs SHALL be zero outside ROUND.
REQ-024 Resolved rm in {101,110,111} SHALL set res_illegal=1, res_mantissa/exponent/inexact/overflow=0, res_sign=latched sign, no fflags update.
REQ-025 Legal op completion in ROUND SHALL OR rnd_overflow into fflags[2] and (rnd_inexact|rnd_overflow) into fflags[0]; other fflags bits never set by this block.
REQ-026 fflags_clr SHALL zero fflags; with simultaneous set in the same cycle, result = newly set bits only.
REQ-027 DONE: res_valid=1 with res_* stable until res_ready; on res_valid&res_ready state -> IDLE; res_valid deasserts next cycle.
REQ-028 Grant-to-res_valid latency SHALL be 2 cycles; minimum issue interval 3 cycles; res_ready held high in DONE gives exactly one handshake.
REQ-029 last_grant SHALL update only on grant; a requester dropping req_valid before grant SHALL not be granted.
REQ-030 res_* outside DONE SHALL hold last captured values; res_valid=0.

Reset
REQ-031 On rst: state=IDLE, last_grant=NREQ-1 (requester 0 highest priority), req_ready=0, res_valid=0, all res_* =0, fflags=0, rnd_* =0, busy=0.
REQ-032 rst asserted mid-operation (ROUND or DONE) SHALL abort the op without res_valid and without fflags update.

Verification
REQ-033 Req0: mantissa 48'h800001_000000, exp 127, GRS=100, rm=000 -> req_ready[0] at T, res_valid at T+2, res_mantissa 23'h000002, res_exponent 127, res_inexact 1, tag 0, fflags 5'b00001.
REQ-034 All three requesters valid continuously, res_ready=1 -> grant order 0,1,2,0, grants every 3 cycles.
REQ-035 Req1 rm=111 with frm=001, mantissa 48'h800000_FFFFFF, GRS=111 -> rnd_rm=001, res_mantissa 0, res_inexact 1; then frm=101 with rm=111 -> res_illegal 1, fflags unchanged.
REQ-036 Req2 mantissa 48'hFFFFFF_000000, exp 254, GRS=111, RNE -> res_exponent 255, res_overflow 1, fflags 5'b00101; fflags_clr same cycle as next set -> only new bits.
REQ-037 res_ready low 5 cycles in DONE -> res_* stable, req_ready stays 0 despite pending req_valid; rst in ROUND -> res_valid never asserts, fflags 0.
